ls_p1: RTL and testbench

// - Second load/store pipeline stage. Consumes the INSTRUCTION_LS record (ls_func, addr, data, rd) produced by ls_p0.
// - Drives a single-outstanding data-memory request: byte lanes, write data replication and word alignment.
// - For loads, aligns and sign/zero-extends the returned word and presents a writeback record to the register file.

---
 rtl/ls_p1.sv | 246 ++++++++++++++++++++++++
 tb/tb_ls_p1.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ls_p1.sv
// Load/store stage 1: single-outstanding data-memory request, byte-lane steering and load extension.
// Optional macro MISALIGN_TRAP_EN turns misaligned halfword/word accesses into a trapping writeback.
package ls_p1_pkg;
    localparam int LS_RD_W = 7;

    typedef enum logic [3:0] {
        LS_NOP, LS_LB, LS_LBU, LS_LH, LS_LHU, LS_LW, LS_SB, LS_SH, LS_SW
    } ls_func_e;

    typedef struct packed {
        ls_func_e             ls_func;
        logic [31:0]          addr;
        logic [31:0]          data;
        logic [LS_RD_W-1:0]   rd;
    } instruction_ls_t;
endpackage

module ls_p1
    import ls_p1_pkg::*;
#(
    parameter int RD_W   = LS_RD_W,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  instruction_ls_t       instruction_i,
    output logic                  ready_i,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [ADDR_W-1:0]     dmem_addr_o,
    output logic [3:0]            dmem_be_o,
    output logic [31:0]           dmem_wdata_o,
    input  logic                  dmem_gnt_i,
    input  logic                  dmem_rvalid_i,
    input  logic [31:0]           dmem_rdata_i,
    output logic                  wb_valid_o,
    output logic [RD_W-1:0]       wb_rd_o,
    output logic [31:0]           wb_data_o,
`ifdef MISALIGN_TRAP_EN
    output logic                  wb_misalign_o,
`endif
    input  logic                  wb_ready_i
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_e;

    state_e              state_reg, state_next;
    logic                ready_reg, ready_next;
    logic                req_reg, req_next;
    logic                we_reg, we_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [3:0]          be_reg, be_next;
    logic [31:0]         wdata_reg, wdata_next;
    ls_func_e            func_reg, func_next;
    logic [1:0]          off_reg, off_next;
    logic [RD_W-1:0]     cmd_rd_reg, cmd_rd_next;
    logic                wb_valid_reg, wb_valid_next;
    logic [RD_W-1:0]     wb_rd_reg, wb_rd_next;
    logic [31:0]         wb_data_reg, wb_data_next;
`ifdef MISALIGN_TRAP_EN
    logic                misalign_reg, misalign_next;
    logic                in_misalign;
`endif

    logic                in_valid, in_store;
    logic [1:0]          in_off;
    logic [3:0]          sb_be;
    logic [31:0]         sb_wdata, sh_wdata;
    logic [1:0]          ld_off;
    logic [31:0]         ld_word, ld_result;

    assign in_valid = (instruction_i.ls_func != LS_NOP);
    assign in_store = instruction_i.ls_func inside {LS_SB, LS_SH, LS_SW};
    assign in_off   = instruction_i.addr[1:0];

    // Store data is replicated across every lane so the byte enables alone select the target bytes.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte_lane
            assign sb_be[gi]            = (in_off == 2'(gi));
            assign sb_wdata[8*gi +: 8]  = instruction_i.data[7:0];
        end
        for (gi = 0; gi < 2; gi++) begin : g_half_lane
            assign sh_wdata[16*gi +: 16] = instruction_i.data[15:0];
        end
    endgenerate

`ifdef MISALIGN_TRAP_EN
    assign in_misalign =
        ((instruction_i.ls_func inside {LS_LH, LS_LHU, LS_SH}) && instruction_i.addr[0]) ||
        ((instruction_i.ls_func inside {LS_LW, LS_SW}) && (instruction_i.addr[1:0] != 2'b00));
`endif

    // Halfword loads drop addr[0] so a misaligned LH silently reads the aligned halfword.
    always_comb begin
        ld_off    = (func_reg inside {LS_LH, LS_LHU}) ? {off_reg[1], 1'b0} : off_reg;
        ld_word   = dmem_rdata_i >> {ld_off, 3'b000};
        ld_result = dmem_rdata_i;
        case (func_reg)
            LS_LB:   ld_result = {{24{ld_word[7]}}, ld_word[7:0]};
            LS_LBU:  ld_result = {24'h0, ld_word[7:0]};
            LS_LH:   ld_result = {{16{ld_word[15]}}, ld_word[15:0]};
            LS_LHU:  ld_result = {16'h0, ld_word[15:0]};
            default: ld_result = dmem_rdata_i;
        endcase
    end

    always_comb begin
        state_next    = state_reg;
        ready_next    = ready_reg;
        req_next      = req_reg;
        we_next       = we_reg;
        addr_next     = addr_reg;
        be_next       = be_reg;
        wdata_next    = wdata_reg;
        func_next     = func_reg;
        off_next      = off_reg;
        cmd_rd_next   = cmd_rd_reg;
        wb_valid_next = wb_valid_reg;
        wb_rd_next    = wb_rd_reg;
        wb_data_next  = wb_data_reg;
`ifdef MISALIGN_TRAP_EN
        misalign_next = misalign_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (ready_reg && in_valid) begin
                    func_next   = instruction_i.ls_func;
                    off_next    = in_off;
                    cmd_rd_next = RD_W'(instruction_i.rd);
                    ready_next  = 1'b0;
`ifdef MISALIGN_TRAP_EN
                    if (in_misalign) begin
                        state_next    = S_WB;
                        wb_valid_next = 1'b1;
                        misalign_next = 1'b1;
                        wb_data_next  = instruction_i.addr;
                        wb_rd_next    = in_store ? '0 : RD_W'(instruction_i.rd);
                    end else
`endif
                    begin
                        state_next = S_REQ;
                        req_next   = 1'b1;
                        we_next    = in_store;
                        addr_next  = {instruction_i.addr[ADDR_W-1:2], 2'b00};
                        case (instruction_i.ls_func)
                            LS_SB: begin
                                be_next    = sb_be;
                                wdata_next = sb_wdata;
                            end
                            LS_SH: begin
                                be_next    = in_off[1] ? 4'b1100 : 4'b0011;
                                wdata_next = sh_wdata;
                            end
                            default: begin
                                be_next    = 4'b1111;
                                wdata_next = instruction_i.data;
                            end
                        endcase
                    end
                end
            end
            S_REQ: begin
                if (dmem_gnt_i) begin
                    req_next = 1'b0;
                    if (we_reg) begin
                        state_next = S_IDLE;
                        ready_next = 1'b1;
                    end else begin
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (dmem_rvalid_i) begin
                    state_next    = S_WB;
                    wb_valid_next = 1'b1;
                    wb_rd_next    = cmd_rd_reg;
                    wb_data_next  = ld_result;
`ifdef MISALIGN_TRAP_EN
                    misalign_next = 1'b0;
`endif
                end
            end
            default: begin
                if (wb_ready_i) begin
                    state_next    = S_IDLE;
                    wb_valid_next = 1'b0;
                    ready_next    = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            ready_reg    <= 1'b1;
            req_reg      <= 1'b0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            be_reg       <= '0;
            wdata_reg    <= '0;
            func_reg     <= LS_NOP;
            off_reg      <= '0;
            cmd_rd_reg   <= '0;
            wb_valid_reg <= 1'b0;
            wb_rd_reg    <= '0;
            wb_data_reg  <= '0;
`ifdef MISALIGN_TRAP_EN
            misalign_reg <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            ready_reg    <= ready_next;
            req_reg      <= req_next;
            we_reg       <= we_next;
            addr_reg     <= addr_next;
            be_reg       <= be_next;
            wdata_reg    <= wdata_next;
            func_reg     <= func_next;
            off_reg      <= off_next;
            cmd_rd_reg   <= cmd_rd_next;
            wb_valid_reg <= wb_valid_next;
            wb_rd_reg    <= wb_rd_next;
            wb_data_reg  <= wb_data_next;
`ifdef MISALIGN_TRAP_EN
            misalign_reg <= misalign_next;
`endif
        end
    end

    assign ready_i      = ready_reg;
    assign dmem_req_o   = req_reg;
    assign dmem_we_o    = we_reg;
    assign dmem_addr_o  = addr_reg;
    assign dmem_be_o    = be_reg;
    assign dmem_wdata_o = wdata_reg;
    assign wb_valid_o   = wb_valid_reg;
    assign wb_rd_o      = wb_rd_reg;
    assign wb_data_o    = wb_data_reg;
`ifdef MISALIGN_TRAP_EN
    assign wb_misalign_o = misalign_reg;
`endif

endmodule

// File: tb/tb_ls_p1.sv
// Testbench for ls_p1: table of transactions with a scoreboard for memory requests and writebacks,
// plus hand sequences for reset-in-flight and (with MISALIGN_TRAP_EN) the misalignment trap.
module tb_ls_p1;
    import ls_p1_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    instruction_ls_t instr;
    logic            ready;
    logic            req, we;
    logic [31:0]     addr;
    logic [3:0]      be;
    logic [31:0]     wdata;
    logic            gnt, rvalid;
    logic [31:0]     rdata;
    logic            wb_valid;
    logic [6:0]      wb_rd;
    logic [31:0]     wb_data;
    logic            wb_ready;
`ifdef MISALIGN_TRAP_EN
    logic            wb_misalign;
`endif

    always #5 clk = ~clk;

    ls_p1 dut (
        .clk           (clk),
        .reset         (reset),
        .instruction_i (instr),
        .ready_i       (ready),
        .dmem_req_o    (req),
        .dmem_we_o     (we),
        .dmem_addr_o   (addr),
        .dmem_be_o     (be),
        .dmem_wdata_o  (wdata),
        .dmem_gnt_i    (gnt),
        .dmem_rvalid_i (rvalid),
        .dmem_rdata_i  (rdata),
        .wb_valid_o    (wb_valid),
        .wb_rd_o       (wb_rd),
        .wb_data_o     (wb_data),
`ifdef MISALIGN_TRAP_EN
        .wb_misalign_o (wb_misalign),
`endif
        .wb_ready_i    (wb_ready)
    );

    typedef struct {
        ls_func_e    func;
        logic [31:0] addr;
        logic [31:0] data;
        logic [6:0]  rd;
        logic [31:0] rdata;
        int          gnt_dly;
        int          rv_dly;
        int          wbr_dly;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_wb;
    } vec_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_wdata;
    } req_exp_t;

    typedef struct {
        logic [6:0]  rd;
        logic [31:0] data;
    } wb_exp_t;

    req_exp_t req_q[$];
    wb_exp_t  wb_q[$];
    vec_t     vecs[$];
    int       n_checks = 0;
    int       n_pass   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else
            n_pass++;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'h0, ready}, 32'h1);
        check({tag, "_req"}, {31'h0, req}, 32'h0);
        check({tag, "_we"}, {31'h0, we}, 32'h0);
        check({tag, "_addr"}, addr, 32'h0);
        check({tag, "_be"}, {28'h0, be}, 32'h0);
        check({tag, "_wdata"}, wdata, 32'h0);
        check({tag, "_wb_valid"}, {31'h0, wb_valid}, 32'h0);
        check({tag, "_wb_rd"}, {25'h0, wb_rd}, 32'h0);
        check({tag, "_wb_data"}, wb_data, 32'h0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", {31'h0, ready}, 32'h1);
    endtask

    task automatic do_txn(input int idx, input vec_t v);
        req_exp_t er;
        wb_exp_t  ew;
        logic     is_ld;
        is_ld = v.func inside {LS_LB, LS_LBU, LS_LH, LS_LHU, LS_LW};
        wait_ready();
        $display("txn %0d func=%0d addr=0x%08h data=0x%08h rd=%0d", idx, v.func, v.addr, v.data, v.rd);
        instr = '{ls_func: v.func, addr: v.addr, data: v.data, rd: v.rd};
        req_q.push_back('{we: !is_ld, addr: v.exp_addr, be: v.exp_be, wdata: v.exp_wdata, chk_wdata: !is_ld});
        if (is_ld) wb_q.push_back('{rd: v.rd, data: v.exp_wb});
        @(negedge clk);
        instr = '{ls_func: LS_NOP, addr: 32'h0, data: 32'h0, rd: 7'h0};
        check("ready_busy", {31'h0, ready}, 32'h0);
        check("req_t1", {31'h0, req}, 32'h1);
        if (req_q.size() == 0) begin
            check("req_q_empty", 32'h1, 32'h0);
            return;
        end
        er = req_q.pop_front();
        check("req_we", {31'h0, we}, {31'h0, er.we});
        check("req_addr", addr, er.addr);
        check("req_be", {28'h0, be}, {28'h0, er.be});
        if (er.chk_wdata) check("req_wdata", wdata, er.wdata);
        for (int k = 0; k < v.gnt_dly; k++) begin
            @(negedge clk);
            check("req_hold", {31'h0, req}, 32'h1);
            check("req_addr_hold", addr, er.addr);
            check("ready_hold_req", {31'h0, ready}, 32'h0);
        end
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        check("req_drop", {31'h0, req}, 32'h0);
        if (!is_ld) begin
            check("store_ready_t2", {31'h0, ready}, 32'h1);
            check("store_no_wb", {31'h0, wb_valid}, 32'h0);
            return;
        end
        check("ready_wait_st", {31'h0, ready}, 32'h0);
        for (int k = 0; k < v.rv_dly; k++) begin
            @(negedge clk);
            check("wb_early", {31'h0, wb_valid}, 32'h0);
        end
        rvalid = 1'b1;
        rdata  = v.rdata;
        @(negedge clk);
        rvalid = 1'b0;
        rdata  = $urandom;
        check("wb_valid", {31'h0, wb_valid}, 32'h1);
        if (wb_q.size() == 0) begin
            check("wb_q_empty", 32'h1, 32'h0);
            return;
        end
        ew = wb_q.pop_front();
        check("wb_rd", {25'h0, wb_rd}, {25'h0, ew.rd});
        check("wb_data", wb_data, ew.data);
`ifdef MISALIGN_TRAP_EN
        check("wb_misalign_clr", {31'h0, wb_misalign}, 32'h0);
`endif
        for (int k = 0; k < v.wbr_dly; k++) begin
            @(negedge clk);
            check("wb_hold_valid", {31'h0, wb_valid}, 32'h1);
            check("wb_hold_data", wb_data, ew.data);
            check("ready_hold_wb", {31'h0, ready}, 32'h0);
        end
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;
        check("wb_release", {31'h0, wb_valid}, 32'h0);
        check("ready_after_wb", {31'h0, ready}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //               func    addr          data          rd  rdata        g  r  w  exp_addr      be       exp_wdata     exp_wb
        vecs.push_back('{LS_SW,  32'h0000_1000, 32'hDEAD_BEEF, 0, 32'h0,       0, 0, 0, 32'h0000_1000, 4'b1111, 32'hDEAD_BEEF, 32'h0});
        vecs.push_back('{LS_SB,  32'h0000_1003, 32'h0000_00A5, 0, 32'h0,       0, 0, 0, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 32'h0});
        vecs.push_back('{LS_SB,  32'h0000_1001, 32'h1234_563C, 0, 32'h0,       1, 0, 0, 32'h0000_1000, 4'b0010, 32'h3C3C_3C3C, 32'h0});
        vecs.push_back('{LS_SH,  32'h0000_1002, 32'h1234_BEEF, 0, 32'h0,       0, 0, 0, 32'h0000_1000, 4'b1100, 32'hBEEF_BEEF, 32'h0});
        vecs.push_back('{LS_SH,  32'h0000_1004, 32'h0000_CAFE, 0, 32'h0,       0, 0, 0, 32'h0000_1004, 4'b0011, 32'hCAFE_CAFE, 32'h0});
        vecs.push_back('{LS_LB,  32'h0000_2001, 32'h0,         5, 32'h0000_8000, 0, 0, 0, 32'h0000_2000, 4'b1111, 32'h0,       32'hFFFF_FF80});
        vecs.push_back('{LS_LBU, 32'h0000_2001, 32'h0,         5, 32'h0000_8000, 0, 0, 0, 32'h0000_2000, 4'b1111, 32'h0,       32'h0000_0080});
        vecs.push_back('{LS_LB,  32'h0000_2002, 32'h0,        11, 32'h127F_0000, 0, 0, 0, 32'h0000_2000, 4'b1111, 32'h0,       32'h0000_007F});
        vecs.push_back('{LS_LH,  32'h0000_2002, 32'h0,         3, 32'h8001_1234, 3, 2, 2, 32'h0000_2000, 4'b1111, 32'h0,       32'hFFFF_8001});
        vecs.push_back('{LS_LH,  32'h0000_2000, 32'h0,         4, 32'h8001_F234, 0, 0, 0, 32'h0000_2000, 4'b1111, 32'h0,       32'hFFFF_F234});
        vecs.push_back('{LS_LHU, 32'h0000_2000, 32'h0,         4, 32'h8001_F234, 0, 1, 1, 32'h0000_2000, 4'b1111, 32'h0,       32'h0000_F234});
        vecs.push_back('{LS_LW,  32'h0000_2004, 32'h0,         0, 32'h89AB_CDEF, 0, 0, 0, 32'h0000_2004, 4'b1111, 32'h0,       32'h89AB_CDEF});
`ifndef MISALIGN_TRAP_EN
        vecs.push_back('{LS_LW,  32'h0000_2007, 32'h0,        12, 32'h1122_3344, 0, 0, 0, 32'h0000_2004, 4'b1111, 32'h0,       32'h1122_3344});
        vecs.push_back('{LS_LHU, 32'h0000_2003, 32'h0,        13, 32'hABCD_0012, 0, 0, 0, 32'h0000_2000, 4'b1111, 32'h0,       32'h0000_ABCD});
        vecs.push_back('{LS_SW,  32'h0000_1006, 32'h0102_0304, 0, 32'h0,       0, 0, 0, 32'h0000_1004, 4'b1111, 32'h0102_0304, 32'h0});
`endif

        reset    = 1'b1;
        instr    = '{ls_func: LS_NOP, addr: 32'h0, data: 32'h0, rd: 7'h0};
        gnt      = 1'b0;
        rvalid   = 1'b0;
        rdata    = 32'h0;
        wb_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", {31'h0, ready}, 32'h1);

        for (int i = 0; i < vecs.size(); i++) do_txn(i, vecs[i]);

        // Reset while a load sits in WAIT; the stray rvalid afterwards must not produce a writeback.
        wait_ready();
        $display("txn reset-in-wait LW addr=0x00002008");
        instr = '{ls_func: LS_LW, addr: 32'h0000_2008, data: 32'h0, rd: 7'd9};
        @(negedge clk);
        instr = '{ls_func: LS_NOP, addr: 32'h0, data: 32'h0, rd: 7'h0};
        check("rst_req", {31'h0, req}, 32'h1);
        gnt = 1'b1;
        @(negedge clk);
        gnt   = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("midrst");
        rvalid = 1'b1;
        rdata  = 32'h5555_AAAA;
        @(negedge clk);
        rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("stray_rvalid_no_wb", {31'h0, wb_valid}, 32'h0);
            @(negedge clk);
        end
        do_txn(100, '{LS_SW, 32'h0000_1010, 32'h7654_3210, 0, 32'h0, 0, 0, 0,
                      32'h0000_1010, 4'b1111, 32'h7654_3210, 32'h0});

`ifdef MISALIGN_TRAP_EN
        // Trapping accesses skip the memory and go straight to a writeback carrying the address.
        for (int t = 0; t < 2; t++) begin
            wait_ready();
            $display("txn misalign %0d", t);
            if (t == 0) instr = '{ls_func: LS_LW, addr: 32'h0000_3002, data: 32'h0, rd: 7'd7};
            else        instr = '{ls_func: LS_SH, addr: 32'h0000_3001, data: 32'h1111, rd: 7'd6};
            @(negedge clk);
            instr = '{ls_func: LS_NOP, addr: 32'h0, data: 32'h0, rd: 7'h0};
            check("mis_no_req", {31'h0, req}, 32'h0);
            check("mis_wb_valid", {31'h0, wb_valid}, 32'h1);
            check("mis_flag", {31'h0, wb_misalign}, 32'h1);
            check("mis_rd", {25'h0, wb_rd}, (t == 0) ? 32'd7 : 32'd0);
            check("mis_data", wb_data, (t == 0) ? 32'h0000_3002 : 32'h0000_3001);
            wb_ready = 1'b1;
            @(negedge clk);
            wb_ready = 1'b0;
            check("mis_release", {31'h0, wb_valid}, 32'h0);
            check("mis_ready", {31'h0, ready}, 32'h1);
        end
`endif

        check("req_q_drained", req_q.size(), 32'h0);
        check("wb_q_drained", wb_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
